// File: rtl/rip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// rip_mem_arbiter : IF/MA request arbiter for one shared single-port word RAM
// Optional IF anti-starvation: define RIP_MEM_ARB_FAIR_EN
// Revision: 1.0
// ============================================================================
module rip_mem_arbiter #(
   parameter int NUM_COL       = 4,
   parameter int COL_WIDTH     = 8,
   parameter int ADDR_WIDTH    = 20,
   parameter int DATA_WIDTH    = NUM_COL*COL_WIDTH,
   parameter int MAX_MA_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [DATA_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  ma_req,
   input  logic [NUM_COL-1:0]    ma_we,
   input  logic [DATA_WIDTH-1:0] ma_addr,
   input  logic [DATA_WIDTH-1:0] ma_wdata,
   output logic                  ma_gnt,
   output logic                  ma_rvalid,
   output logic [DATA_WIDTH-1:0] ma_rdata,
   output logic                  mem_en,
   output logic [NUM_COL-1:0]    mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_IF_RESP = 2'd1,
      S_MA_RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  ma_rd_q, ma_rd_d;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] ma_rdata_q;
   logic                  force_if;

`ifdef RIP_MEM_ARB_FAIR_EN
   localparam int SW = $clog2(MAX_MA_STREAK + 1);
   logic [SW-1:0] streak_q, streak_d;

   // Counts MA grants that made a waiting IF lose; saturates and then hands IF one grant.
   always_comb begin
      streak_d = streak_q;
      if (if_gnt || !if_req)
         streak_d = '0;
      else if (ma_gnt && (streak_q != SW'(MAX_MA_STREAK)))
         streak_d = streak_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) streak_q <= '0;
      else     streak_q <= streak_d;
   end

   assign force_if = if_req && (streak_q == SW'(MAX_MA_STREAK));
`else
   logic unused_streak_cfg;
   assign unused_streak_cfg = (MAX_MA_STREAK != 0);
   assign force_if          = 1'b0;
`endif

   assign ma_gnt = !rst && ma_req && !force_if;
   assign if_gnt = !rst && if_req && !ma_gnt;

   assign mem_en    = if_gnt || ma_gnt;
   assign mem_we    = ma_gnt ? ma_we : '0;
   assign mem_addr  = ma_gnt ? ma_addr[ADDR_WIDTH+1:2] : if_addr[ADDR_WIDTH+1:2];
   assign mem_wdata = ma_wdata;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[1:0], ma_addr[1:0],
                               if_addr[DATA_WIDTH-1:ADDR_WIDTH+2],
                               ma_addr[DATA_WIDTH-1:ADDR_WIDTH+2]};

   always_comb begin
      state_d   = S_IDLE;
      ma_rd_d   = ma_rd_q;
      if_rvalid = 1'b0;
      ma_rvalid = 1'b0;
      if_rdata  = if_rdata_q;
      ma_rdata  = ma_rdata_q;
      if (ma_gnt) begin
         state_d = S_MA_RESP;
         ma_rd_d = (ma_we == '0);
      end else if (if_gnt) begin
         state_d = S_IF_RESP;
      end
      // Response data is forwarded straight from the RAM, then held in the _q copy.
      if (rst) begin
         if_rdata = '0;
         ma_rdata = '0;
      end else begin
         case (state_q)
            S_IF_RESP: begin
               if_rvalid = 1'b1;
               if_rdata  = mem_rdata;
            end
            S_MA_RESP: begin
               ma_rvalid = 1'b1;
               if (ma_rd_q) ma_rdata = mem_rdata;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ma_rd_q    <= 1'b0;
         if_rdata_q <= '0;
         ma_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         ma_rd_q    <= ma_rd_d;
         if_rdata_q <= if_rdata;
         ma_rdata_q <= ma_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rip_mem_arbiter.sv
`default_nettype none
// tb_rip_mem_arbiter : scoreboard bench with a behavioural RAM behind the arbiter.
module tb_rip_mem_arbiter;
   localparam int NUM_COL = 4;
   localparam int DW      = 32;
   localparam int AW      = 20;
   localparam int MAX     = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0, ma_req = 1'b0;
   logic [DW-1:0] if_addr = '0, ma_addr = '0, ma_wdata = '0;
   logic [3:0]    ma_we = '0;
   logic          if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_en;
   logic [DW-1:0] if_rdata, ma_rdata, mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;

   rip_mem_arbiter #(.NUM_COL(NUM_COL), .COL_WIDTH(8), .ADDR_WIDTH(AW),
                     .DATA_WIDTH(DW), .MAX_MA_STREAK(MAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
      .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   logic [DW-1:0] ram [256];
   wire unused_tb_addr = ^mem_addr[AW-1:8];
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < NUM_COL; b++)
            if (mem_we[b]) ram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         mem_rdata <= ram[mem_addr[7:0]];
      end
   end

   typedef struct packed {
      logic          is_ma;
      logic          is_wr;
      logic [DW-1:0] data;
   } resp_t;

   resp_t         sb[$];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] hold_if = '0, hold_ma = '0;
   int            m_streak = 0;
   int            n_pass = 0, n_total = 0;
   bit            mon_en = 1'b0;

   task automatic predict(output logic e_if, output logic e_ma);
      logic f;
      f = 1'b0;
`ifdef RIP_MEM_ARB_FAIR_EN
      f = if_req && (m_streak == MAX);
`endif
      e_ma = !rst && ma_req && !f;
      e_if = !rst && if_req && !e_ma;
   endtask

   task automatic commit(input logic e_if, input logic e_ma);
      logic [DW-1:0] w;
      if (e_ma) begin
         w = ref_mem[ma_addr[9:2]];
         if (ma_we != 4'b0) begin
            for (int b = 0; b < NUM_COL; b++)
               if (ma_we[b]) w[b*8 +: 8] = ma_wdata[b*8 +: 8];
            ref_mem[ma_addr[9:2]] = w;
            sb.push_back(resp_t'{is_ma: 1'b1, is_wr: 1'b1, data: w});
         end else begin
            sb.push_back(resp_t'{is_ma: 1'b1, is_wr: 1'b0, data: w});
         end
      end else if (e_if) begin
         sb.push_back(resp_t'{is_ma: 1'b0, is_wr: 1'b0, data: ref_mem[if_addr[9:2]]});
      end
      if (rst || e_if || !if_req) m_streak = 0;
      else if (e_ma && m_streak < MAX) m_streak++;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard: one pop per cycle following a grant.
   always begin
      resp_t e;
      @(posedge clk);
      #3;
      if (mon_en) begin
         if (rst) begin
            sb.delete();
            hold_if = '0;
            hold_ma = '0;
            n_total++; if ({if_rvalid, ma_rvalid} !== 2'b00) $display("FAIL rst_rvalid got %b want 00", {if_rvalid, ma_rvalid}); else n_pass++;
         end else if (sb.size() != 0) begin
            e = sb.pop_front();
            n_total++; if ({if_rvalid, ma_rvalid} !== {!e.is_ma, e.is_ma}) $display("FAIL resp_route got if/ma=%b want %b", {if_rvalid, ma_rvalid}, {!e.is_ma, e.is_ma}); else n_pass++;
            if (!e.is_ma) hold_if = e.data;
            else if (!e.is_wr) hold_ma = e.data;
         end else begin
            n_total++; if ({if_rvalid, ma_rvalid} !== 2'b00) $display("FAIL idle_rvalid got %b want 00", {if_rvalid, ma_rvalid}); else n_pass++;
         end
         n_total++; if (if_rdata !== hold_if) $display("FAIL if_rdata got %h want %h", if_rdata, hold_if); else n_pass++;
         n_total++; if (ma_rdata !== hold_ma) $display("FAIL ma_rdata got %h want %h", ma_rdata, hold_ma); else n_pass++;
      end
   end

   task automatic test_reset();
      logic e_if, e_ma;
      rst = 1'b1; if_req = 1'b1; ma_req = 1'b1; ma_we = 4'b0;
      if_addr = 32'h40; ma_addr = 32'h80;
      repeat (2) begin
         @(negedge clk);
         n_total++; if ({if_gnt, ma_gnt, mem_en} !== 3'b000) $display("FAIL rst_gnt got %b want 000", {if_gnt, ma_gnt, mem_en}); else n_pass++;
         n_total++; if ((if_rdata | ma_rdata) !== '0) $display("FAIL rst_rdata got %h/%h want 0", if_rdata, ma_rdata); else n_pass++;
         predict(e_if, e_ma);
         commit(e_if, e_ma);
         next_cycle();
      end
      rst = 1'b0;
      @(negedge clk);
      predict(e_if, e_ma);
      n_total++; if ({if_gnt, ma_gnt} !== 2'b01) $display("FAIL first_gnt got %b want 01", {if_gnt, ma_gnt}); else n_pass++;
      commit(e_if, e_ma);
      next_cycle();
      if_req = 1'b0; ma_req = 1'b0;
      @(negedge clk);
      next_cycle();
   endtask

   task automatic test_if_read();
      logic e_if, e_ma;
      if_req = 1'b1; if_addr = 32'h40;
      @(negedge clk);
      predict(e_if, e_ma);
      n_total++; if ({if_gnt, ma_gnt, mem_en} !== 3'b101) $display("FAIL if_gnt got %b want 101", {if_gnt, ma_gnt, mem_en}); else n_pass++;
      n_total++; if (mem_addr !== 20'h10 || mem_we !== 4'b0) $display("FAIL if_mem got addr=%h we=%b want 10/0000", mem_addr, mem_we); else n_pass++;
      commit(e_if, e_ma);
      next_cycle();
      if_req = 1'b0;
      @(negedge clk);
      n_total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) $display("FAIL if_resp got v=%b d=%h want 1/deadbeef", if_rvalid, if_rdata); else n_pass++;
      next_cycle();
      @(negedge clk);
      n_total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) $display("FAIL if_hold got v=%b d=%h want 0/deadbeef", if_rvalid, if_rdata); else n_pass++;
      next_cycle();
   endtask

   task automatic test_ma_write_read();
      logic e_if, e_ma;
      ma_req = 1'b1; ma_we = 4'b0100; ma_wdata = 32'h00AB0000; ma_addr = 32'h40;
      @(negedge clk);
      predict(e_if, e_ma);
      n_total++; if ({ma_gnt, mem_we} !== 5'b1_0100 || mem_wdata !== 32'h00AB0000) $display("FAIL ma_wr got g=%b we=%b wd=%h want 1/0100/00ab0000", ma_gnt, mem_we, mem_wdata); else n_pass++;
      commit(e_if, e_ma);
      next_cycle();
      ma_we = 4'b0;
      @(negedge clk);
      predict(e_if, e_ma);
      n_total++; if (ma_rvalid !== 1'b1 || ma_rdata !== 32'h0) $display("FAIL ma_wr_ack got v=%b d=%h want 1/0", ma_rvalid, ma_rdata); else n_pass++;
      commit(e_if, e_ma);
      next_cycle();
      ma_req = 1'b0;
      @(negedge clk);
      n_total++; if (ma_rvalid !== 1'b1 || ma_rdata !== 32'hDEABBEEF) $display("FAIL ma_rd got v=%b d=%h want 1/deabbeef", ma_rvalid, ma_rdata); else n_pass++;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic e_if, e_ma;
      // {if_req, ma_req, ma_we, addr, wdata}
      logic [69:0] tbl [7];
      tbl[0] = {1'b0, 1'b1, 4'b1111, 32'h48, 32'h12345678};
      tbl[1] = {1'b1, 1'b0, 4'b0000, 32'h48, 32'h0};
      tbl[2] = {1'b0, 1'b1, 4'b0000, 32'h40, 32'h0};
      tbl[3] = {1'b1, 1'b0, 4'b0000, 32'h40, 32'h0};
      tbl[4] = {1'b0, 1'b1, 4'b0011, 32'h4C, 32'h0000CAFE};
      tbl[5] = {1'b1, 1'b1, 4'b0000, 32'h4C, 32'h0};
      tbl[6] = {1'b1, 1'b0, 4'b0000, 32'h4C, 32'h0};
      for (int i = 0; i < 7; i++) begin
         {if_req, ma_req, ma_we, ma_addr, ma_wdata} = tbl[i];
         if_addr = ma_addr;
         @(negedge clk);
         predict(e_if, e_ma);
         n_total++; if ({if_gnt, ma_gnt, mem_en} !== {e_if, e_ma, e_if | e_ma}) $display("FAIL b2b_gnt[%0d] got %b want %b", i, {if_gnt, ma_gnt, mem_en}, {e_if, e_ma, e_if | e_ma}); else n_pass++;
         commit(e_if, e_ma);
         next_cycle();
      end
      if_req = 1'b0; ma_req = 1'b0;
      @(negedge clk);
      next_cycle();
   endtask

   task automatic test_contention();
      logic e_if, e_ma;
      int   n_if;
      n_if = 0;
      if_req = 1'b1; ma_req = 1'b1; ma_we = 4'b0; if_addr = 32'h40; ma_addr = 32'h48;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         predict(e_if, e_ma);
         n_total++; if ({if_gnt, ma_gnt} !== {e_if, e_ma}) $display("FAIL cont_gnt[%0d] got %b want %b", i, {if_gnt, ma_gnt}, {e_if, e_ma}); else n_pass++;
         if (if_gnt) n_if++;
         commit(e_if, e_ma);
         next_cycle();
      end
`ifdef RIP_MEM_ARB_FAIR_EN
      n_total++; if (n_if !== 2) $display("FAIL cont_if_count got %0d want 2", n_if); else n_pass++;
`else
      n_total++; if (n_if !== 0) $display("FAIL cont_if_count got %0d want 0", n_if); else n_pass++;
`endif
      if_req = 1'b0; ma_req = 1'b0;
      @(negedge clk);
      commit(1'b0, 1'b0);
      next_cycle();
   endtask

   task automatic test_reset_midflight();
      logic e_if, e_ma;
      if_req = 1'b1; if_addr = 32'h48;
      @(negedge clk);
      predict(e_if, e_ma);
      n_total++; if (if_gnt !== 1'b1) $display("FAIL mid_gnt got %b want 1", if_gnt); else n_pass++;
      commit(e_if, e_ma);
      next_cycle();
      rst = 1'b1; if_req = 1'b0;
      @(negedge clk);
      n_total++; if (if_rvalid !== 1'b0 || if_rdata !== '0 || ma_rdata !== '0) $display("FAIL mid_rst got v=%b d=%h/%h want 0/0/0", if_rvalid, if_rdata, ma_rdata); else n_pass++;
      commit(1'b0, 1'b0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (if_rvalid !== 1'b0 || if_rdata !== '0) $display("FAIL post_rst got v=%b d=%h want 0/0", if_rvalid, if_rdata); else n_pass++;
      next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout, %0d/%0d checks passed so far", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      ram[8'h10]     = 32'hDEADBEEF;
      ref_mem[8'h10] = 32'hDEADBEEF;
      next_cycle();
      mon_en = 1'b1;
      test_reset();
      test_if_read();
      test_ma_write_read();
      test_back_to_back();
      test_contention();
      test_reset_midflight();
      repeat (2) next_cycle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/rip_mem_arbiter.md
# rip_mem_arbiter

- Shares one single-port, word-organised block RAM between two requesters:
  - instruction-fetch (IF) port: read-only;
  - memory-access (MA) port: read/write with byte lanes.
- Sits between the pipeline's IF/MA stages and the memory array.
- Uses a request/grant handshake with a fixed one-cycle read latency.
- Routes each response back to the requester that issued it.

## Interface
Parameters:
- NUM_COL, 4, byte lanes per word
- COL_WIDTH, 8, bits per lane
- ADDR_WIDTH, 20, word-address width of the RAM
- DATA_WIDTH, NUM_COL*COL_WIDTH, data port width
- MAX_MA_STREAK, 4, consecutive MA grants allowed while IF waits (used only with the fairness macro)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF read request
- if_addr  in  DATA_WIDTH  IF byte address; bits [1:0] ignored
- if_gnt  out  1  IF request accepted this cycle (combinational)
- if_rvalid  out  1  IF read data valid
- if_rdata  out  DATA_WIDTH  IF read data; held until next IF response
- ma_req  in  1  MA request
- ma_we  in  NUM_COL  per-lane write strobes; all-zero means read
- ma_addr  in  DATA_WIDTH  MA byte address; bits [1:0] ignored
- ma_wdata  in  DATA_WIDTH  lane-aligned write data
- ma_gnt  out  1  MA request accepted this cycle (combinational)
- ma_rvalid  out  1  MA completion; carries read data for reads, acts as ack for writes
- ma_rdata  out  DATA_WIDTH  MA read data; held until next MA read response
- mem_en  out  1  RAM access enable
- mem_we  out  NUM_COL  RAM lane write enables
- mem_addr  out  ADDR_WIDTH  RAM word address, equal to addr[ADDR_WIDTH+1:2]
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after mem_en

## Operation
- Requester holds req, address, strobes and data stable until it sees gnt high in the same cycle. Dropping req before gnt is legal and withdraws the request.
- At most one grant per cycle. The granted request drives mem_en=1 and mem_* combinationally in that cycle.
  - MA grant: mem_we=ma_we, mem_wdata=ma_wdata.
  - IF grant: mem_we=0.
- With no grant: mem_en=0, mem_we=0.
- FSM (registered response tag): IDLE, IF_RESP, MA_RESP. The next state is whichever port was granted this cycle, else IDLE.
  - In IF_RESP: if_rvalid=1, if_rdata<=mem_rdata.
  - In MA_RESP: ma_rvalid=1. For reads only (registered we==0), ma_rdata<=mem_rdata. For writes, ma_rdata is unchanged.
- Priority: MA wins whenever ma_req=1 (strict priority; the MA stage blocks the pipeline).
- Back-to-back grants are allowed every cycle, including alternating IF/MA.
- Reset values: state IDLE, if_rvalid=0, ma_rvalid=0, if_rdata=0, ma_rdata=0, streak counter 0. While rst=1: if_gnt=0, ma_gnt=0, mem_en=0.
- Reset mid-operation: a response pending for the cycle after rst is discarded. The rvalid outputs are 0 and the data registers are cleared.

## Timing
- Grant in cycle N → rvalid in cycle N+1 with data from mem_rdata. Latency is exactly 1, with no bubble between consecutive grants.
- Read-after-write to the same word: MA write granted in N, IF or MA read granted in N+1 → the read returns the post-write data (RAM write-first is not required, since the write lands at the end of N).
- Simultaneous if_req and ma_req: ma_gnt=1, if_gnt=0. IF retries the following cycle.
- rvalid pulses for one cycle per grant. There is no backpressure on responses; requesters always accept.

## Configuration
- RIP_MEM_ARB_FAIR_EN defined:
  - A counter of consecutive MA grants taken while if_req=1 saturates at MAX_MA_STREAK.
  - When it reaches MAX_MA_STREAK and if_req=1, the next grant goes to IF even if ma_req=1.
  - The counter clears on any IF grant or whenever if_req=0.
- RIP_MEM_ARB_FAIR_EN undefined: strict MA priority. No counter is synthesised and IF may starve indefinitely.

## Test plan
- Reset: assert rst 2 cycles with if_req=ma_req=1 → gnts=0, mem_en=0, rvalids=0, rdata=0 throughout. First grant is ma_gnt in the first cycle after rst falls.
- IF read: preload word 0x10 with 0xDEADBEEF, if_req with if_addr=0x40 → if_gnt same cycle, mem_addr=0x10, if_rvalid=1 and if_rdata=0xDEADBEEF next cycle, held after.
- MA byte write then read: ma_we=4'b0100, ma_wdata=0x00AB0000, addr=0x40. Next cycle MA read of addr 0x40 → returns 0xDEABBEEF. ma_rvalid pulses both cycles and ma_rdata changes only on the read.
- Contention, macro off: if_req and ma_req held high 10 cycles → ma_gnt all 10 cycles, if_gnt never.
- Contention, RIP_MEM_ARB_FAIR_EN with MAX_MA_STREAK=4 → grant pattern MA,MA,MA,MA,IF repeating, with rvalid routed to the matching port each following cycle.
- Reset mid-flight: IF granted in cycle N, rst=1 in N+1 → if_rvalid=0 in N+1 and if_rdata=0.
